mlp_layer_scheduler: RTL and testbench
======================================

Name: mlp_layer_scheduler

Overview:
- Control-only scheduler that shares one multi-layer MLP datapath among NUM_REQ requesters.
- Arbitrates round-robin between requesters.
- Sequences the granted job through the layers in order, using each linear layer's enable/done pair.
- Guards every layer with a timeout watchdog. Sits between the requester front-ends and the chained linear layers; carries no data.

Parameters:
NUM_REQ, 4, number of requesters sharing the MLP (>=2)
NUM_LAYERS, 2, number of chained linear layers sequenced per job (>=1)
TIMEOUT_CYCLES, 1024, max cycles a layer may hold enable without done (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
req  in  NUM_REQ  per-requester job request, level
grant  out  NUM_REQ  one-hot grant, held for the whole job
grant_id  out  IDW=max(1,$clog2(NUM_REQ))  index of granted requester
done_out  out  NUM_REQ  one-cycle completion pulse to the granted requester
layer_enable  out  NUM_LAYERS  enable to each layer; at most one bit high
layer_done  in  NUM_LAYERS  per-layer done, level, valid while that layer's enable is high
cur_layer  out  LW=max(1,$clog2(NUM_LAYERS))  active layer index
busy  out  1  job in progress (RUN or FIN)
err_pulse  out  1  one-cycle timeout indication
err_sticky  out  1  set on any timeout, cleared only by reset

Behaviour:
- Reset (rst==0 at edge): state=IDLE; all outputs 0; rr pointer=NUM_REQ-1, so req[0] has top priority first. Any in-flight job is abandoned and no done_out is issued.
- FSM states: IDLE, RUN, FIN, ERR. All outputs are registered.
- IDLE:
  - If |req at edge t, pick the first set bit scanning from (ptr+1) mod NUM_REQ upward with wrap.
  - From cycle t+1: grant one-hot, grant_id=winner, ptr=winner, busy=1, cur_layer=0, layer_enable[0]=1, watchdog=0. State goes to RUN.
  - No req: stay in IDLE with outputs 0.
- RUN (layer k=cur_layer):
  - layer_enable[k] is held at 1; the watchdog increments every cycle.
  - layer_done[k]==1 at edge, k<NUM_LAYERS-1: next cycle layer_enable[k]=0, layer_enable[k+1]=1, cur_layer=k+1, watchdog=0. This is a zero-gap handover.
  - layer_done[k]==1 at edge, k==NUM_LAYERS-1: next cycle all enables are 0, state=FIN.
  - layer_done[j] for j!=k is ignored.
  - Watchdog==TIMEOUT_CYCLES-1 with no done: next cycle all enables are 0 and state=ERR. Done on that same edge wins over timeout.
- FIN: done_out[grant_id]=1 for exactly one cycle while grant stays high. Next cycle grant=0, busy=0, state=IDLE.
- ERR:
  - For one cycle: err_pulse=1, err_sticky=1, done_out[grant_id]=1, grant still high, cur_layer holds the failing layer.
  - Next cycle: IDLE with grant=0.
- Minimum job latency: request to done_out is NUM_LAYERS+1 cycles when each layer returns done in its first enabled cycle. There is one idle cycle between jobs.
- Requester rules:
  - Dropping req mid-job has no effect; the job runs to completion.
  - req still high after done_out counts as a new request, arbitrated round-robin after the others.
- Simultaneous events:
  - New reqs arriving during RUN/FIN/ERR are only sampled in IDLE.
  - rst==0 overrides everything, including an edge where done would otherwise fire.
- Watchdog is a $clog2(TIMEOUT_CYCLES)+1-bit unsigned counter and does not wrap within a layer.

Decomposition:
- Package mlp_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} sched_state_t
  - localparam functions for IDW/LW width computation
- Sub-module rr_arbiter (parameter N):
  - combinational one-hot pick from req and ptr;
  - reusable for other shared-resource arbitration in the codebase.

Test Plan:
- Single job: req=4'b0010 at cycle 0, done pulsed on first enabled cycle of each layer -> grant=0010 at cycle 1, enable[0] cycle 1, enable[1] cycle 2, done_out[1] at cycle 3, grant=0 at cycle 4.
- Round-robin fairness: req=4'b1111 held, layers respond immediately -> grant order 0,1,2,3,0; each job 4 cycles apart; never two grants high.
- Timeout: TIMEOUT_CYCLES=8, layer 1 never asserts done -> enable[1] high exactly 8 cycles, then err_pulse=1 with cur_layer=1, done_out pulse, err_sticky stays 1 until rst=0.
- Done on timeout edge: layer_done[0]=1 on watchdog==7 (TIMEOUT_CYCLES=8) -> normal advance to layer 1, no error.
- Reset mid-job: rst=0 for one edge during RUN layer 1 -> next cycle all outputs 0, no done_out; req[2] then granted before req[3].
- Spurious done: layer_done[1]=1 while cur_layer=0 -> ignored; sequencing waits for layer_done[0].

Source files
------------

// File: rtl/mlp_sched_pkg.sv
// Shared types and width helpers for the MLP layer scheduler and its arbiter.
package mlp_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} sched_state_t;

  // Index width that stays at least one bit for single-entry cases.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_lw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter
  import mlp_sched_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = calc_idw(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);

  logic found;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        gnt_id                   = W'((int'(ptr) + i) % N);
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mlp_layer_scheduler.sv
// Shares one chained-layer MLP datapath among requesters: round-robin grant,
// in-order layer sequencing via enable/done, and a per-layer timeout watchdog.
module mlp_layer_scheduler
  import mlp_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int NUM_LAYERS     = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDW            = calc_idw(NUM_REQ),
  localparam int LW             = calc_lw(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  output logic [IDW-1:0]        grant_id,
  output logic [NUM_REQ-1:0]    done_out,
  output logic [NUM_LAYERS-1:0] layer_enable,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [LW-1:0]         cur_layer,
  output logic                  busy,
  output logic                  err_pulse,
  output logic                  err_sticky
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

  sched_state_t         state;
  logic [IDW-1:0]       ptr;
  logic [WDW-1:0]       wdog;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDW-1:0]       arb_id;
  logic                 done_hit;
  logic                 timeout;
  logic                 last_layer;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Masking with the one-hot enable ignores done from any inactive layer.
  assign done_hit   = |(layer_done & layer_enable);
  assign timeout    = (wdog == WDW'(TIMEOUT_CYCLES - 1));
  assign last_layer = (cur_layer == LW'(NUM_LAYERS - 1));

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge values regardless of statement order.
    if (!rst) begin
      state        <= IDLE;
      ptr          <= IDW'(NUM_REQ - 1);
      wdog         <= '0;
      grant        <= '0;
      grant_id     <= '0;
      done_out     <= '0;
      layer_enable <= '0;
      cur_layer    <= '0;
      busy         <= 1'b0;
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      done_out  <= '0;
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state        <= RUN;
            grant        <= arb_gnt;
            grant_id     <= arb_id;
            ptr          <= arb_id;
            busy         <= 1'b1;
            cur_layer    <= '0;
            layer_enable <= NUM_LAYERS'(1);
            wdog         <= '0;
          end
        end
        RUN: begin
          // Done on the timeout edge takes precedence over the watchdog.
          if (done_hit) begin
            wdog <= '0;
            if (last_layer) begin
              layer_enable <= '0;
              done_out     <= grant;
              state        <= FIN;
            end else begin
              layer_enable <= layer_enable << 1;
              cur_layer    <= cur_layer + 1'b1;
            end
          end else if (timeout) begin
            layer_enable <= '0;
            busy         <= 1'b0;
            err_pulse    <= 1'b1;
            err_sticky   <= 1'b1;
            done_out     <= grant;
            state        <= ERR;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        FIN, ERR: begin
          state     <= IDLE;
          grant     <= '0;
          grant_id  <= '0;
          busy      <= 1'b0;
          cur_layer <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_scheduler.sv
// Directed bench for mlp_layer_scheduler with NUM_REQ=4, NUM_LAYERS=2, TIMEOUT_CYCLES=8.
module tb_mlp_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [3:0] done_out;
  logic [1:0] layer_enable;
  logic [1:0] layer_done;
  logic [1:0] manual_done;
  logic       auto_resp;
  logic       cur_layer;
  logic       busy;
  logic       err_pulse;
  logic       err_sticky;

  int errors = 0;
  int checks = 0;

  mlp_layer_scheduler #(
    .NUM_REQ        (4),
    .NUM_LAYERS     (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .grant_id     (grant_id),
    .done_out     (done_out),
    .layer_enable (layer_enable),
    .layer_done   (layer_done),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  // Layers either answer in their first enabled cycle or follow manual_done.
  assign layer_done = auto_resp ? layer_enable : manual_done;

  // Snapshot {grant, grant_id, done_out, layer_enable, cur_layer, busy, err_pulse, err_sticky}.
  function automatic logic [15:0] snap();
    return {grant, grant_id, done_out, layer_enable, cur_layer, busy, err_pulse, err_sticky};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; auto_resp = 1'b1; manual_done = '0;
    tick(); tick();
    checks++;
    if (snap() !== 16'h0000) begin errors++; $display("FAIL reset_outputs: got %b want %b", snap(), 16'h0000); end
    rst = 1'b1;
  endtask

  task automatic test_single_job();
    logic [15:0] exp_s;
    req = 4'b0010;
    tick();
    exp_s = {4'b0010, 2'd1, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL single_c1: got %b want %b", snap(), exp_s); end
    req = '0;
    tick();
    exp_s = {4'b0010, 2'd1, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL single_c2: got %b want %b", snap(), exp_s); end
    tick();
    exp_s = {4'b0010, 2'd1, 4'b0010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL single_c3_done: got %b want %b", snap(), exp_s); end
    tick();
    checks++;
    if (snap() !== 16'h0000) begin errors++; $display("FAIL single_c4_idle: got %b want %b", snap(), 16'h0000); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    rst = 1'b0; tick(); rst = 1'b1;
    auto_resp = 1'b1;
    req = 4'b1111;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      exp_g = 4'b0001 << (((cyc - 1) / 4) % 4);
      checks++;
      if ($countones(grant) > 1) begin errors++; $display("FAIL rr_onehot c%0d: got %b want at most one bit", cyc, grant); end
      if ((cyc - 1) % 4 == 0) begin
        checks++;
        if (grant !== exp_g || grant_id !== 2'(((cyc - 1) / 4) % 4)) begin
          errors++; $display("FAIL rr_grant c%0d: got %b/%0d want %b/%0d", cyc, grant, grant_id, exp_g, ((cyc - 1) / 4) % 4);
        end
      end
      if ((cyc - 1) % 4 == 2) begin
        checks++;
        if (done_out !== exp_g) begin errors++; $display("FAIL rr_done c%0d: got %b want %b", cyc, done_out, exp_g); end
      end
      if (cyc == 18) req = '0;
    end
    checks++;
    if (snap() !== 16'h0000) begin errors++; $display("FAIL rr_idle_gap: got %b want %b", snap(), 16'h0000); end
    tick();
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL rr_no_req: got %b want %b", grant, 4'b0000); end
  endtask

  task automatic test_timeout();
    logic [15:0] exp_s;
    auto_resp = 1'b0; manual_done = '0;
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || layer_enable !== 2'b01) begin errors++; $display("FAIL to_start: got %b/%b want 0001/01", grant, layer_enable); end
    manual_done = 2'b01; req = '0;
    tick();
    manual_done = 2'b00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (layer_enable !== 2'b10 || err_pulse !== 1'b0) begin
        errors++; $display("FAIL to_en1_held i%0d: got en=%b err=%b want en=10 err=0", i, layer_enable, err_pulse);
      end
      tick();
    end
    exp_s = {4'b0001, 2'd0, 4'b0001, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL to_err_cycle: got %b want %b", snap(), exp_s); end
    tick();
    exp_s = {4'b0000, 2'd0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL to_after_err: got %b want %b", snap(), exp_s); end
    tick(); tick();
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL to_sticky_hold: got %b want %b", snap(), exp_s); end
  endtask

  task automatic test_done_on_timeout_edge();
    logic [15:0] exp_s;
    auto_resp = 1'b0; manual_done = '0;
    req = 4'b0001;
    tick();
    req = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (layer_enable !== 2'b01) begin errors++; $display("FAIL edge_en0_held i%0d: got %b want 01", i, layer_enable); end
    end
    manual_done = 2'b01;
    tick();
    exp_s = {4'b0001, 2'd0, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL edge_advance: got %b want %b", snap(), exp_s); end
    manual_done = 2'b10;
    tick();
    exp_s = {4'b0001, 2'd0, 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL edge_fin: got %b want %b", snap(), exp_s); end
    manual_done = '0;
    tick();
  endtask

  task automatic test_spurious_done();
    logic [15:0] exp_s;
    auto_resp = 1'b0;
    manual_done = 2'b10;
    req = 4'b0001;
    tick();
    req = '0;
    exp_s = {4'b0001, 2'd0, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (snap() !== exp_s) begin errors++; $display("FAIL spur_hold i%0d: got %b want %b", i, snap(), exp_s); end
      if (i < 2) tick();
    end
    manual_done = 2'b01;
    tick();
    checks++;
    if (layer_enable !== 2'b10 || cur_layer !== 1'b1) begin errors++; $display("FAIL spur_advance: got %b/%b want 10/1", layer_enable, cur_layer); end
    manual_done = 2'b10;
    tick();
    checks++;
    if (done_out !== 4'b0001) begin errors++; $display("FAIL spur_done: got %b want 0001", done_out); end
    manual_done = '0;
    tick();
  endtask

  task automatic test_reset_mid_job();
    logic [15:0] exp_s;
    auto_resp = 1'b0; manual_done = '0;
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("FAIL rst_first_grant: got %b/%0d want 1000/3", grant, grant_id); end
    manual_done = 2'b01; req = '0;
    tick();
    exp_s = {4'b1000, 2'd3, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    checks++;
    if (snap() !== exp_s) begin errors++; $display("FAIL rst_layer1: got %b want %b", snap(), exp_s); end
    rst = 1'b0; manual_done = 2'b10;
    tick();
    checks++;
    if (snap() !== 16'h0000) begin errors++; $display("FAIL rst_abandon: got %b want %b", snap(), 16'h0000); end
    rst = 1'b1; req = 4'b1100; auto_resp = 1'b1; manual_done = '0;
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin errors++; $display("FAIL rst_grant2: got %b/%0d want 0100/2", grant, grant_id); end
    tick(); tick();
    checks++;
    if (done_out !== 4'b0100) begin errors++; $display("FAIL rst_done2: got %b want 0100", done_out); end
    tick(); tick();
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant3: got %b/%0d want 1000/3", grant, grant_id); end
    req = '0;
    tick(); tick();
    checks++;
    if (done_out !== 4'b1000) begin errors++; $display("FAIL rst_done3: got %b want 1000", done_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_timeout();
    test_done_on_timeout_edge();
    test_spurious_done();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
